ram16_arbiter: RTL and testbench
================================

Name: ram16_arbiter

Overview:
- Round-robin arbiter that shares one single-port synchronous memory (ram16-style array: write, addr, wdata, rdata) between NUM_REQ requesters.
- Accepts at most one read or write per cycle using a valid/ready handshake on each requester port.
- Tracks in-flight reads through a tag pipeline so that each read response returns only to the requester that issued it.
- Sits between the bus-side clients and the memory macro.

Parameters:
NUM_REQ, 2, number of requester ports (2..8)
ADDR_W, 4, memory address width
DATA_W, 8, memory data width
RD_LAT, 1, memory read latency in cycles: mem_rdata is valid RD_LAT cycles after the read cycle (1..4)

Ports:
clk  input  1  clock; all logic is on the rising edge
rst  input  1  synchronous reset, active-high
req_valid  input  NUM_REQ  per-requester request valid
req_ready  output  NUM_REQ  per-requester grant, one-hot or zero
req_write  input  NUM_REQ  1 = write, 0 = read
req_addr  input  NUM_REQ*ADDR_W  flattened addresses; requester i occupies slice [i*ADDR_W +: ADDR_W]
req_wdata  input  NUM_REQ*DATA_W  flattened write data; same slicing scheme
rsp_valid  output  NUM_REQ  one-hot read-response strobe
rsp_rdata  output  DATA_W  read data, shared by all requesters; qualified by rsp_valid
mem_en  output  1  memory access strobe
mem_write  output  1  memory write enable
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data
busy  output  1  high while any read is in flight

Behaviour:
- Reset (rst high at an edge):
  - rr_ptr <= 0.
  - Tag pipeline is cleared; rsp_valid <= 0 and rsp_rdata <= 0.
  - While rst is high, req_ready = 0 and mem_en = 0.
  - A read in flight when reset asserts is discarded; it never produces a response.
- Grant (combinational within the cycle):
  - Search req_valid starting at index rr_ptr and wrapping modulo NUM_REQ.
  - The first set bit becomes the winner g, and req_ready = one-hot(g).
  - If no bit is set, req_ready = 0.
- Transfer:
  - A transfer occurs when req_valid[g] & req_ready[g].
  - In the same cycle: mem_en = 1, mem_write = req_write[g], mem_addr = slice g of req_addr, mem_wdata = slice g of req_wdata.
  - With no transfer: mem_en = 0, mem_write = 0, mem_addr and mem_wdata = 0.
- Pointer update: on a transfer, rr_ptr <= (g+1) mod NUM_REQ; otherwise rr_ptr holds.
- Fairness: a requester holding req_valid is granted within NUM_REQ cycles.
- Requester obligation: hold valid, write, addr and wdata stable until ready. The arbiter does not check this.
- Read tag pipeline:
  - RD_LAT+1 stages, each holding {vld, id[$clog2(NUM_REQ)]}.
  - A read transfer at cycle T loads stage 0 with {1, g}; a write or idle cycle loads {0, x}.
  - At T+RD_LAT the arbiter samples mem_rdata into rsp_rdata.
  - At T+RD_LAT+1, rsp_valid[id] = 1 for exactly one cycle.
  - Total request-to-response latency is RD_LAT+1 cycles.
- Pipelining: back-to-back reads from any mix of requesters are accepted every cycle, and responses come back in issue order.
- Writes produce no response; write data is committed at the transfer edge.
- Read after write to the same address in the next cycle returns the new data, because the memory is write-before-read on consecutive cycles.
- busy = OR of all stage vld bits.
- Default outputs with nothing pending: rsp_valid = 0. rsp_rdata holds its last value and is only meaningful while rsp_valid is high.

Decomposition:
- Package ram16_arb_pkg holds:
  - the localparam ID_W = $clog2(NUM_REQ) (minimum 1);
  - the typedef rd_tag_t {logic vld; logic [ID_W-1:0] id;};
  - the function rr_pick(valid, ptr), which returns the winner index and a found flag.
- Sub-module rr_arbiter holds rr_ptr and the grant logic (req_valid, advance, gnt_onehot, gnt_idx).
- The top level holds the memory mux and the tag pipeline.

Test Plan:
- Reset: hold rst for 3 cycles with all req_valid = 2'b11 → req_ready = 0 and mem_en = 0 throughout. First grant after reset goes to requester 0.
- Round-robin: req_valid = 2'b11, continuous reads, addr0 = 4'h2, addr1 = 4'h5 → grants alternate 0,1,0,1. rsp_valid alternates 01,10 starting cycle RD_LAT+1 after the first grant.
- Write then read: req0 writes 8'hA5 to addr 4'h3, then req1 reads 4'h3 → rsp_valid = 2'b10 with rsp_rdata = 8'hA5 exactly 2 cycles (RD_LAT=1) after the read grant.
- Single requester streaming: only req1 valid for 8 cycles → req_ready[1] = 1 every cycle, 8 responses in order, and busy drops 2 cycles after the last read.
- Reset mid-flight: read accepted at cycle T, rst asserted at T+1 → no rsp_valid at T+2; busy = 0 after the reset edge.
- Configuration sweep: NUM_REQ = 3, RD_LAT = 3, all three requesters valid → grant order 0,1,2,0. Each response arrives at grant cycle + 4 with the correct id, checked against a scoreboard model of the memory.

Source files
------------

// File: rtl/ram16_arb_pkg.sv
// Shared types and the round-robin search used by the ram16 arbiter.
// Tag ids are sized for the largest supported requester count.
package ram16_arb_pkg;

    localparam int MAX_REQ = 8;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Wide enough for any legal NUM_REQ, so one tag type serves every configuration.
    localparam int ID_W = id_width(MAX_REQ);

    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
    } rd_tag_t;

    typedef struct packed {
        logic            found;
        logic [ID_W-1:0] idx;
    } pick_t;

    // First set bit of valid at or after ptr, wrapping modulo n.
    function automatic pick_t rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input logic [ID_W-1:0]    ptr,
        input int                 n
    );
        pick_t res;
        int    j;
        res = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (k < n) begin
                j = int'(ptr) + k;
                if (j >= n) begin
                    j = j - n;
                end
                if (!res.found && valid[j]) begin
                    res.found = 1'b1;
                    res.idx   = ID_W'(j);
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ram16_arbiter_rr.sv
// Round-robin grant generator: holds the rotating priority pointer and
// produces a one-hot grant plus its index for the current cycle.
module rr_arbiter
    import ram16_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic               advance,
    output logic [NUM_REQ-1:0] gnt_onehot,
    output logic [ID_W-1:0]    gnt_idx
);

    logic [ID_W-1:0]    rr_ptr_reg;
    logic [ID_W-1:0]    rr_ptr_next;
    logic [MAX_REQ-1:0] valid_ext;
    pick_t              pick;
    logic               gnt_found;

    always_comb begin
        valid_ext                = '0;
        valid_ext[NUM_REQ-1:0]   = req_valid;
        pick                     = rr_pick(valid_ext, rr_ptr_reg, NUM_REQ);
    end

    // No grant may be visible while reset is held.
    assign gnt_found = pick.found & ~rst;
    assign gnt_idx   = pick.idx;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
            assign gnt_onehot[gi] = gnt_found & (pick.idx == ID_W'(gi));
        end
    endgenerate

    assign rr_ptr_next = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_reg <= '0;
        end else if (advance) begin
            rr_ptr_reg <= rr_ptr_next;
        end
    end

endmodule

// File: rtl/ram16_arbiter.sv
// Shares one single-port synchronous memory between NUM_REQ requesters and
// routes each read response back to its issuer via a tag pipeline.
module ram16_arbiter
    import ram16_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 8,
    parameter int RD_LAT  = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      mem_en,
    output logic                      mem_write,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic                      busy
);

    logic [NUM_REQ-1:0] gnt_onehot;
    logic [ID_W-1:0]    gnt_idx;
    logic               transfer;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .advance    (transfer),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx)
    );

    assign req_ready = gnt_onehot;
    assign transfer  = |(req_valid & gnt_onehot);

    // AND-OR mux: unselected slices contribute zero, so idle cycles drive zeros.
    logic [NUM_REQ-1:0] write_sel;
    logic [ADDR_W-1:0]  addr_sel  [NUM_REQ];
    logic [DATA_W-1:0]  wdata_sel [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_sel
            assign write_sel[gi] = gnt_onehot[gi] & req_write[gi];
            assign addr_sel[gi]  = {ADDR_W{gnt_onehot[gi]}} & req_addr[gi*ADDR_W +: ADDR_W];
            assign wdata_sel[gi] = {DATA_W{gnt_onehot[gi]}} & req_wdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    always_comb begin
        mem_en    = transfer;
        mem_write = |write_sel;
        mem_addr  = '0;
        mem_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            mem_addr  = mem_addr | addr_sel[i];
            mem_wdata = mem_wdata | wdata_sel[i];
        end
    end

    // Stage k is visible k+1 cycles after the read; stage RD_LAT-1 lines up
    // with valid mem_rdata, and stage RD_LAT with the response cycle.
    rd_tag_t            tag_reg [RD_LAT+1];
    rd_tag_t            tag_in;
    logic [NUM_REQ-1:0] rsp_valid_reg;
    logic [NUM_REQ-1:0] rsp_valid_next;
    logic [DATA_W-1:0]  rsp_rdata_reg;

    always_comb begin
        tag_in.vld = transfer & ~mem_write;
        tag_in.id  = gnt_idx;
    end

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
            assign rsp_valid_next[gi] = tag_reg[RD_LAT-1].vld &
                                        (tag_reg[RD_LAT-1].id == ID_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k <= RD_LAT; k++) begin
                tag_reg[k] <= '0;
            end
            rsp_valid_reg <= '0;
            rsp_rdata_reg <= '0;
        end else begin
            tag_reg[0] <= tag_in;
            for (int k = 1; k <= RD_LAT; k++) begin
                tag_reg[k] <= tag_reg[k-1];
            end
            rsp_valid_reg <= rsp_valid_next;
            if (tag_reg[RD_LAT-1].vld) begin
                rsp_rdata_reg <= mem_rdata;
            end
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;

    always_comb begin
        busy = 1'b0;
        for (int k = 0; k <= RD_LAT; k++) begin
            busy = busy | tag_reg[k].vld;
        end
    end

endmodule

// File: tb/tb_ram16_arbiter.sv
// Scoreboard bench for ram16_arbiter: two configurations (2 req / latency 1 and
// 3 req / latency 3), each with its own memory macro, reference model and monitor.
module tb_ram16_arbiter;

    localparam int AW = 4;
    localparam int DW = 8;

    typedef struct {
        int due;
        int id;
        int data;
    } exp_t;

    logic clk;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc_cnt  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic logic [7:0] init_val(input int a);
        return 8'(a * 37 + 11);
    endfunction

    task automatic chk(input string name, input int lane, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL lane%0d cyc %0d %s: got %0h expected %0h", lane, cyc_cnt, name, act, exp);
        end
    endtask

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            localparam int N = (gi == 0) ? 2 : 3;
            localparam int L = (gi == 0) ? 1 : 3;

            logic            rst;
            logic [N-1:0]    req_valid, req_ready, req_write, rsp_valid;
            logic [N*AW-1:0] req_addr;
            logic [N*DW-1:0] req_wdata;
            logic [DW-1:0]   rsp_rdata, mem_wdata, mem_rdata;
            logic [AW-1:0]   mem_addr;
            logic            mem_en, mem_write, busy;
            bit              done = 1'b0;
            exp_t            sb[$];

            ram16_arbiter #(
                .NUM_REQ (N),
                .ADDR_W  (AW),
                .DATA_W  (DW),
                .RD_LAT  (L)
            ) u_dut (
                .clk       (clk),
                .rst       (rst),
                .req_valid (req_valid),
                .req_ready (req_ready),
                .req_write (req_write),
                .req_addr  (req_addr),
                .req_wdata (req_wdata),
                .rsp_valid (rsp_valid),
                .rsp_rdata (rsp_rdata),
                .mem_en    (mem_en),
                .mem_write (mem_write),
                .mem_addr  (mem_addr),
                .mem_wdata (mem_wdata),
                .mem_rdata (mem_rdata),
                .busy      (busy)
            );

            // Memory macro: registered read delayed to RD_LAT cycles; garbage when not reading.
            logic [DW-1:0] ram     [16];
            logic [DW-1:0] rd_pipe [L];

            always @(posedge clk) begin
                if (cyc_cnt == 0) begin
                    for (int k = 0; k < 16; k++) ram[k] <= init_val(k);
                end else if (mem_en && mem_write) begin
                    ram[mem_addr] <= mem_wdata;
                end
                rd_pipe[0] <= (mem_en && !mem_write) ? ram[mem_addr] : DW'($urandom);
                for (int k = 1; k < L; k++) rd_pipe[k] <= rd_pipe[k-1];
            end
            assign mem_rdata = rd_pipe[L-1];

            // Reference model: predicts the grant, checks the memory port, pushes expected reads.
            initial begin
                int            ptr;
                int            g;
                int            idx;
                logic          wr;
                logic [AW-1:0] a;
                logic [DW-1:0] d;
                logic [DW-1:0] mm [16];
                ptr = 0;
                for (int k = 0; k < 16; k++) mm[k] = init_val(k);
                forever begin
                    @(negedge clk);
                    #1;
                    g = -1;
                    if (!rst) begin
                        for (int k = 0; k < N; k++) begin
                            idx = (ptr + k) % N;
                            if (g < 0 && req_valid[idx]) g = idx;
                        end
                    end
                    chk("req_ready", gi, 32'(req_ready), (g < 0) ? 0 : (1 << g));
                    chk("mem_en", gi, 32'(mem_en), 32'(g >= 0));
                    if (g >= 0) begin
                        wr = req_write[g];
                        a  = req_addr[g*AW +: AW];
                        d  = req_wdata[g*DW +: DW];
                        chk("mem_write", gi, 32'(mem_write), 32'(wr));
                        chk("mem_addr", gi, 32'(mem_addr), 32'(a));
                        if (wr) begin
                            chk("mem_wdata", gi, 32'(mem_wdata), 32'(d));
                            mm[a] = d;
                        end else begin
                            sb.push_back('{due: cyc_cnt + L + 1, id: g, data: int'(mm[a])});
                        end
                        ptr = (g + 1) % N;
                    end else begin
                        chk("mem_idle", gi, {19'd0, mem_write, mem_addr, mem_wdata}, 0);
                    end
                    if (rst) ptr = 0;
                end
            end

            // Monitor: compares responses and busy against the scoreboard queue.
            initial begin
                exp_t e;
                forever begin
                    @(negedge clk);
                    chk("busy", gi, 32'(busy), 32'(sb.size() != 0));
                    if (sb.size() != 0 && sb[0].due == cyc_cnt) begin
                        e = sb.pop_front();
                        chk("rsp_valid", gi, 32'(rsp_valid), 1 << e.id);
                        chk("rsp_rdata", gi, 32'(rsp_rdata), e.data);
                        $display("lane%0d cyc %0d rsp id=%0d data=%02h", gi, cyc_cnt, e.id, rsp_rdata);
                    end else begin
                        chk("rsp_valid_idle", gi, 32'(rsp_valid), 0);
                    end
                    if (rst) sb.delete();
                end
            end

            // Stimulus: requesters hold their request until granted.
            logic [N-1:0] v;
            logic [N-1:0] rdy;

            task automatic cyc();
                req_valid = v;
                @(negedge clk);
                rdy = req_ready;
                @(posedge clk);
                #1;
                v = v & ~rdy;
                req_valid = v;
            endtask

            task automatic set_req(input int i, input bit wr, input int a, input int d);
                req_write[i]         = wr;
                req_addr[i*AW +: AW] = AW'(a);
                req_wdata[i*DW +: DW] = DW'(d);
                v[i]                 = 1'b1;
            endtask

            task automatic wait_granted(input int i);
                for (int t = 0; t < 20 && v[i]; t++) cyc();
                chk("grant_wait", gi, 32'(v[i]), 0);
            endtask

            function automatic int dir_addr(input int i);
                return (i == 0) ? 2 : (i == 1) ? 5 : i + 8;
            endfunction

            initial begin
                rst       = 1'b1;
                v         = '0;
                req_valid = '0;
                req_write = '0;
                req_addr  = '0;
                req_wdata = '0;
                for (int i = 0; i < N; i++) set_req(i, 1'b0, dir_addr(i), 0);
                repeat (3) cyc();
                rst = 1'b0;
                // All requesters reading continuously.
                repeat (8) begin
                    for (int i = 0; i < N; i++) if (!v[i]) set_req(i, 1'b0, dir_addr(i), 0);
                    cyc();
                end
                for (int t = 0; t < 20 && v != '0; t++) cyc();
                chk("drain_all", gi, 32'(v), 0);
                // Write then read the same address on the next cycle.
                set_req(0, 1'b1, 3, 8'hA5);
                wait_granted(0);
                set_req(1, 1'b0, 3, 0);
                wait_granted(1);
                repeat (2) cyc();
                // Single requester streaming.
                for (int k = 0; k < 8; k++) begin
                    set_req(1, 1'b0, k, 0);
                    cyc();
                end
                repeat (L + 3) cyc();
                // Reset one cycle after a read is accepted.
                set_req(0, 1'b0, 7, 0);
                cyc();
                rst = 1'b1;
                v   = '0;
                cyc();
                rst = 1'b0;
                repeat (L + 3) cyc();
                // Randomized mixed traffic.
                repeat (400) begin
                    for (int i = 0; i < N; i++) begin
                        if (!v[i] && $urandom_range(0, 99) < 60)
                            set_req(i, ($urandom_range(0, 9) < 4), $urandom_range(0, 15),
                                    $urandom_range(0, 255));
                    end
                    cyc();
                end
                for (int t = 0; t < 40 && v != '0; t++) cyc();
                chk("drain_random", gi, 32'(v), 0);
                repeat (L + 4) cyc();
                done = 1'b1;
            end
        end
    endgenerate

    initial begin
        for (int t = 0; t < 20000 && !(g_lane[0].done && g_lane[1].done); t++) @(posedge clk);
        if (!(g_lane[0].done && g_lane[1].done)) begin
            n_fail++;
            $display("FAIL watchdog: stimulus did not complete within cycle budget");
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
